seq_magnitude_comparator: RTL
=============================

# seq_magnitude_comparator

Parametrised, sequential magnitude comparator. It compares two WIDTH-bit operands SLICE bits per clock, most significant slice first, and stops early on the first differing slice. It reports mutually exclusive gt/eq/lt flags with a start/done handshake and supports unsigned or two's-complement operands. It is the multi-bit, clocked successor to the combinational two-bit inequality block, and serves as the shared comparator for threshold and limit checks on the Elbert V2 board.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2 and an integer multiple of SLICE.
- SLICE, 2, bits compared per clock; 1 ≤ SLICE ≤ WIDTH; NSLICE = WIDTH/SLICE ≤ 255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse when the result is updated.
- gt  output  1  A > B; registered; held until the next done.
- eq  output  1  A == B; registered; held until the next done.
- lt  output  1  A < B; registered; held until the next done.
- cycles  output  8  number of slices examined for the last result (1..NSLICE); held.

## Operation
- States: IDLE, CMP, DONE. Reset enters IDLE.
- Reset values: busy=0, done=0, gt=0, eq=0, lt=0, cycles=0; shift registers and slice counter cleared.
- IDLE, start=1:
  - Load a_sh←a and b_sh←b.
  - If signed_mode=1, invert bit WIDTH-1 of both loaded copies. This offset-binary trick lets the signed compare run as an unsigned compare.
  - Set count←0 and go to CMP.
- CMP, each cycle, using top slices sa = a_sh[WIDTH-1 -: SLICE] and sb = b_sh[WIDTH-1 -: SLICE]:
  - sa > sb: gt←1, eq←0, lt←0, cycles←count+1, go to DONE.
  - sa < sb: lt←1, gt←0, eq←0, cycles←count+1, go to DONE.
  - sa == sb and count == NSLICE-1: eq←1, gt←0, lt←0, cycles←NSLICE, go to DONE.
  - Otherwise: shift a_sh and b_sh left by SLICE, count←count+1, stay in CMP.
- DONE (lasts exactly one cycle): done=1.
  - start=1: load the new operands as in IDLE and go to CMP (back-to-back accepted).
  - start=0: go to IDLE.
- start in CMP is ignored. Changes to a, b or signed_mode after the sampling edge do not affect the compare in flight.
- gt, eq and lt are one-hot after the first done and all zero before it. They change only on the edge that enters DONE.
- Reset mid-compare aborts immediately. Outputs return to their reset values and no done is issued for the aborted request.

## Timing
- start sampled at edge E0; busy=1 from E0.
- A result decided at slice i (1-based) is registered at edge E0+i. done, the flags and cycles are valid in the cycle following E0+i.
- Latency from the start edge to done: i cycles. Best case 1, worst case NSLICE (equal operands, or a difference only in the last slice).
- busy falls on the same edge that done rises. done and busy are never high together.
- Throughput with back-to-back starts: one result per (i+1) cycles.
- Purely synchronous datapath. rst_n acts asynchronously on assertion; release is expected to be synchronised externally.

## Test plan
All scenarios use WIDTH=16, SLICE=2, NSLICE=8 unless stated.

- Reset: hold rst_n=0 for 3 cycles with start=1 → busy=done=gt=eq=lt=0 and cycles=0 throughout; no compare starts while rst_n=0.
- Early exit: unsigned a=16'h8000, b=16'h7FFF → 1 cycle after start: done=1, gt=1, eq=lt=0, cycles=1.
- Equal: a=b=16'h1234 → done exactly 8 cycles after start, eq=1, cycles=8; start held high during CMP is ignored (no restart).
- Signed: a=16'hFFFF, b=16'h0001 with signed_mode=1 → lt=1, cycles=1. The same operands with signed_mode=0 → gt=1, cycles=1.
- Last-slice difference and back-to-back:
  - a=16'h0003, b=16'h0002 → gt=1, cycles=8.
  - start asserted in the DONE cycle with a=16'h0001, b=16'h0002 → next done 8 cycles later with lt=1.
- Abort and exhaustive:
  - rst_n pulsed low 3 cycles into a compare → no done; the next start completes normally.
  - With WIDTH=2, SLICE=1, all 16 (a,b) pairs in both modes → flags match a>b / a==b / a<b.

Source files
------------

// File: rtl/seq_magnitude_comparator_if.sv
// rtl/seq_magnitude_comparator_if.sv - start/done handshake and result bus for the sequential comparator
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;
   logic [7:0]       cycles;

   modport master (
      output start, a, b, signed_mode,
      input  busy, done, gt, eq, lt, cycles
   );

   modport slave (
      input  start, a, b, signed_mode,
      output busy, done, gt, eq, lt, cycles
   );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - MSB-first slice-serial magnitude comparator with early exit
module seq_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int SLICE = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   seq_magnitude_comparator_if.slave bus
);
   localparam int               NSLICE   = WIDTH / SLICE;
   localparam logic [7:0]       LAST_IDX = 8'(NSLICE - 1);
   localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [7:0]       count;
   logic             busy_q;
   logic             done_q;
   logic             gt_q;
   logic             eq_q;
   logic             lt_q;
   logic [7:0]       cycles_q;
   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [WIDTH-1:0] sign_flip;

   assign sa = a_sh[WIDTH-1 -: SLICE];
   assign sb = b_sh[WIDTH-1 -: SLICE];
   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign sign_flip = bus.signed_mode ? SIGN_BIT : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         count    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         cycles_q <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh   <= bus.a ^ sign_flip;
                  b_sh   <= bus.b ^ sign_flip;
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= CMP;
               end else begin
                  state <= IDLE;
               end
            end
            CMP: begin
               if ((sa != sb) || (count == LAST_IDX)) begin
                  gt_q     <= (sa > sb);
                  eq_q     <= (sa == sb);
                  lt_q     <= (sa < sb);
                  cycles_q <= count + 8'd1;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else begin
                  a_sh  <= a_sh << SLICE;
                  b_sh  <= b_sh << SLICE;
                  count <= count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.gt     = gt_q;
   assign bus.eq     = eq_q;
   assign bus.lt     = lt_q;
   assign bus.cycles = cycles_q;
endmodule
